// File: rtl/mpsoc_ahb_spram_initiator.sv
// AHB-Lite initiator: turns single local commands (SINGLE or INCR bursts of
// 1..16 beats) into pipelined AHB-Lite transfers. Bursts restart with NONSEQ
// at every 1 KB boundary, and a two-cycle ERROR response aborts the command.
module mpsoc_ahb_spram_initiator #(
  parameter int HADDR_SIZE = 64,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  req_i,
  input  logic                  req_we_i,
  input  logic [HADDR_SIZE-1:0] req_addr_i,
  input  logic [2:0]            req_size_i,
  input  logic [4:0]            req_len_i,
  input  logic [3:0]            req_prot_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic [HDATA_SIZE-1:0] wdat_i,
  output logic                  wdat_ack_o,
  output logic [HDATA_SIZE-1:0] rdat_o,
  output logic                  rdat_valid_o,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_BURST, ST_LAST, ST_ERR} state_t;

  state_t                  state_reg, state_next;
  logic [HADDR_SIZE-1:0]   haddr_reg;
  logic [HDATA_SIZE-1:0]   hwdata_reg;
  logic                    hwrite_reg;
  logic [2:0]              hsize_reg;
  logic [2:0]              hburst_reg;
  logic [3:0]              hprot_reg;
  logic [1:0]              htrans_reg;
  logic [4:0]              cnt_reg;      // address phases left, including the one on the bus
  logic                    dphase_reg;   // a data phase is in progress this cycle
  logic                    done_reg;
  logic                    err_reg;

  logic                    addr_phase;
  logic                    addr_accept;
  logic                    dphase_err;
  logic [4:0]              len_eff;
  logic [HADDR_SIZE-1:0]   addr_aligned;
  logic [HADDR_SIZE-1:0]   addr_incr;
  logic [HADDR_SIZE-1:0]   addr_next;

  // Shared events: address accepted, first cycle of an ERROR response, length clamp
  always_comb begin
    addr_phase   = (state_reg == ST_ADDR) || (state_reg == ST_BURST);
    addr_accept  = addr_phase && HREADY;
    dphase_err   = dphase_reg && HRESP && !HREADY;
    len_eff      = req_len_i;
    if (req_len_i == 5'd0) begin
      len_eff = 5'd1;
    end else if (req_len_i > 5'd16) begin
      len_eff = 5'd16;
    end
    addr_aligned = req_addr_i & ({HADDR_SIZE{1'b1}} << req_size_i);
    addr_incr    = {{(HADDR_SIZE-1){1'b0}}, 1'b1} << hsize_reg;
    addr_next    = haddr_reg + addr_incr;
  end

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req_i) state_next = ST_ADDR;
      ST_ADDR,
      ST_BURST: begin
        if (dphase_err) begin
          state_next = ST_ERR;
        end else if (addr_accept) begin
          state_next = (cnt_reg == 5'd1) ? ST_LAST : ST_BURST;
        end
      end
      ST_LAST: begin
        if (dphase_err) begin
          state_next = ST_ERR;
        end else if (HREADY) begin
          state_next = ST_IDLE;
        end
      end
      ST_ERR:   if (HREADY && HRESP) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Combinational outputs: busy, write-data pop, read-data stream
  always_comb begin
    busy_o       = (state_reg != ST_IDLE);
    wdat_ack_o   = addr_accept && hwrite_reg;
    rdat_valid_o = dphase_reg && !hwrite_reg && HREADY && !HRESP;
    rdat_o       = rdat_valid_o ? HRDATA : '0;
  end

  // Registered bus outputs, beat counter and completion pulses
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      haddr_reg  <= '0;
      hwdata_reg <= '0;
      hwrite_reg <= 1'b0;
      hsize_reg  <= 3'b000;
      hburst_reg <= BURST_SINGLE;
      hprot_reg  <= 4'b0011;
      htrans_reg <= TRANS_IDLE;
      cnt_reg    <= 5'd0;
      dphase_reg <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_i) begin
            haddr_reg  <= addr_aligned;
            htrans_reg <= TRANS_NONSEQ;
            hwrite_reg <= req_we_i;
            hsize_reg  <= req_size_i;
            hburst_reg <= (len_eff == 5'd1) ? BURST_SINGLE : BURST_INCR;
            hprot_reg  <= req_prot_i;
            cnt_reg    <= len_eff;
            dphase_reg <= 1'b0;
          end
        end
        ST_ADDR,
        ST_BURST: begin
          if (dphase_err) begin
            // Drop the pending address phase and every beat behind it
            htrans_reg <= TRANS_IDLE;
            dphase_reg <= 1'b0;
          end else if (HREADY) begin
            dphase_reg <= 1'b1;
            if (hwrite_reg) begin
              hwdata_reg <= wdat_i;
            end
            if (cnt_reg == 5'd1) begin
              htrans_reg <= TRANS_IDLE;
            end else begin
              cnt_reg    <= cnt_reg - 5'd1;
              haddr_reg  <= addr_next;
              htrans_reg <= (addr_next[9:0] == 10'd0) ? TRANS_NONSEQ : TRANS_SEQ;
            end
          end
        end
        ST_LAST: begin
          if (dphase_err) begin
            dphase_reg <= 1'b0;
          end else if (HREADY) begin
            dphase_reg <= 1'b0;
            done_reg   <= 1'b1;
          end
        end
        ST_ERR: begin
          if (HREADY && HRESP) begin
            done_reg <= 1'b1;
            err_reg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign HADDR     = haddr_reg;
  assign HWDATA    = hwdata_reg;
  assign HWRITE    = hwrite_reg;
  assign HSIZE     = hsize_reg;
  assign HBURST    = hburst_reg;
  assign HPROT     = hprot_reg;
  assign HTRANS    = htrans_reg;
  assign HMASTLOCK = 1'b0;
  assign done_o    = done_reg;
  assign err_o     = err_reg;

endmodule

// File: tb/tb_mpsoc_ahb_spram_initiator.sv
// Directed bench for mpsoc_ahb_spram_initiator: single write, waited read
// burst, 1 KB split, ERROR abort, back-to-back, length/alignment, reset abort.
module tb_mpsoc_ahb_spram_initiator;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_i;
  logic        req_we_i;
  logic [63:0] req_addr_i;
  logic [2:0]  req_size_i;
  logic [4:0]  req_len_i;
  logic [3:0]  req_prot_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] wdat_i;
  logic        wdat_ack_o;
  logic [31:0] rdat_o;
  logic        rdat_valid_o;
  logic [63:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ack_cnt  = 32'd0;
  logic [31:0] rd_cnt   = 32'd0;
  logic [31:0] done_cnt = 32'd0;
  logic [31:0] rd_log [0:31];

  always #5 HCLK = ~HCLK;

  mpsoc_ahb_spram_initiator #(.HADDR_SIZE(64), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_size_i(req_size_i), .req_len_i(req_len_i), .req_prot_i(req_prot_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wdat_i(wdat_i), .wdat_ack_o(wdat_ack_o),
    .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o),
    .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // Write-data source: a FIFO whose head is DEADBEEF plus the number of pops so far
  assign wdat_i = 32'hDEAD_BEEF + ack_cnt;

  // Pulse counters and read-data log
  always @(posedge HCLK) begin
    if (wdat_ack_o) ack_cnt <= ack_cnt + 32'd1;
    if (done_o) done_cnt <= done_cnt + 32'd1;
    if (rdat_valid_o) begin
      rd_log[rd_cnt[4:0]] <= rdat_o;
      rd_cnt <= rd_cnt + 32'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One bus cycle: advance past the edge, drive slave response, let logic settle
  task automatic tick(input logic rdy, input logic resp, input logic [31:0] rd);
    @(posedge HCLK);
    #1;
    req_i  = 1'b0;
    HREADY = rdy;
    HRESP  = resp;
    HRDATA = rd;
    #1;
  endtask

  task automatic issue(input logic we, input logic [63:0] a, input logic [2:0] sz,
                       input logic [4:0] ln, input logic [3:0] pr);
    req_i      = 1'b1;
    req_we_i   = we;
    req_addr_i = a;
    req_size_i = sz;
    req_len_i  = ln;
    req_prot_i = pr;
  endtask

  initial begin
    HRESET = 1'b1; req_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_size_i = '0; req_len_i = '0; req_prot_i = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    repeat (3) tick(1'b1, 1'b0, 32'h0);

    // Reset state
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 64'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_hprot", HPROT, 4'b0011);
    chk("rst_hburst", HBURST, 3'b000);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_mastlock", HMASTLOCK, 1'b0);
    HRESET = 1'b0;

    // Single write at 0x100
    issue(1'b1, 64'h100, 3'd2, 5'd1, 4'hA);
    tick(1'b1, 1'b0, 32'h0);
    chk("sw_c1_htrans", HTRANS, 2'b10);
    chk("sw_c1_haddr", HADDR, 64'h100);
    chk("sw_c1_hburst", HBURST, 3'b000);
    chk("sw_c1_hwrite", HWRITE, 1'b1);
    chk("sw_c1_hsize", HSIZE, 3'd2);
    chk("sw_c1_hprot", HPROT, 4'hA);
    chk("sw_c1_busy", busy_o, 1'b1);
    chk("sw_c1_ack", wdat_ack_o, 1'b1);
    tick(1'b1, 1'b0, 32'h0);
    chk("sw_c2_hwdata", HWDATA, 32'hDEAD_BEEF);
    chk("sw_c2_htrans", HTRANS, 2'b00);
    chk("sw_c2_ack", wdat_ack_o, 1'b0);
    chk("sw_c2_done", done_o, 1'b0);
    tick(1'b1, 1'b0, 32'h0);
    chk("sw_c3_done", done_o, 1'b1);
    chk("sw_c3_err", err_o, 1'b0);
    chk("sw_c3_busy", busy_o, 1'b0);

    // 4-beat read at 0x200 with two wait states on beat 2
    issue(1'b0, 64'h200, 3'd2, 5'd4, 4'h3);
    tick(1'b1, 1'b0, 32'h0);
    chk("rb_c1_htrans", HTRANS, 2'b10);
    chk("rb_c1_haddr", HADDR, 64'h200);
    chk("rb_c1_hburst", HBURST, 3'b001);
    chk("rb_c1_valid", rdat_valid_o, 1'b0);
    tick(1'b1, 1'b0, 32'h1111_0000);
    chk("rb_c2_htrans", HTRANS, 2'b11);
    chk("rb_c2_haddr", HADDR, 64'h204);
    chk("rb_c2_valid", rdat_valid_o, 1'b1);
    chk("rb_c2_rdat", rdat_o, 32'h1111_0000);
    tick(1'b0, 1'b0, 32'h0);
    chk("rb_w1_haddr", HADDR, 64'h208);
    chk("rb_w1_valid", rdat_valid_o, 1'b0);
    tick(1'b0, 1'b0, 32'h0);
    chk("rb_w2_haddr", HADDR, 64'h208);
    chk("rb_w2_htrans", HTRANS, 2'b11);
    tick(1'b1, 1'b0, 32'h2222_0001);
    chk("rb_c5_haddr", HADDR, 64'h208);
    chk("rb_c5_valid", rdat_valid_o, 1'b1);
    tick(1'b1, 1'b0, 32'h3333_0002);
    chk("rb_c6_haddr", HADDR, 64'h20C);
    chk("rb_c6_htrans", HTRANS, 2'b11);
    tick(1'b1, 1'b0, 32'h4444_0003);
    chk("rb_c7_htrans", HTRANS, 2'b00);
    chk("rb_c7_valid", rdat_valid_o, 1'b1);
    chk("rb_c7_done", done_o, 1'b0);
    tick(1'b1, 1'b0, 32'h0);
    chk("rb_done", done_o, 1'b1);
    chk("rb_err", err_o, 1'b0);
    chk("rb_count", rd_cnt, 32'd4);
    chk("rb_log0", rd_log[0], 32'h1111_0000);
    chk("rb_log1", rd_log[1], 32'h2222_0001);
    chk("rb_log2", rd_log[2], 32'h3333_0002);
    chk("rb_log3", rd_log[3], 32'h4444_0003);

    // 1 KB crossing: write 4 beats at 0x3F8
    issue(1'b1, 64'h3F8, 3'd2, 5'd4, 4'h3);
    tick(1'b1, 1'b0, 32'h0);
    chk("kb_c1_htrans", HTRANS, 2'b10);
    chk("kb_c1_haddr", HADDR, 64'h3F8);
    tick(1'b1, 1'b0, 32'h0);
    chk("kb_c2_htrans", HTRANS, 2'b11);
    chk("kb_c2_haddr", HADDR, 64'h3FC);
    chk("kb_c2_hwdata", HWDATA, 32'hDEAD_BEF0);
    tick(1'b1, 1'b0, 32'h0);
    chk("kb_c3_htrans", HTRANS, 2'b10);
    chk("kb_c3_haddr", HADDR, 64'h400);
    chk("kb_c3_hwdata", HWDATA, 32'hDEAD_BEF1);
    tick(1'b1, 1'b0, 32'h0);
    chk("kb_c4_htrans", HTRANS, 2'b11);
    chk("kb_c4_haddr", HADDR, 64'h404);
    tick(1'b1, 1'b0, 32'h0);
    chk("kb_c5_htrans", HTRANS, 2'b00);
    chk("kb_c5_hwdata", HWDATA, 32'hDEAD_BEF3);
    chk("kb_c5_ack", wdat_ack_o, 1'b0);
    tick(1'b1, 1'b0, 32'h0);
    chk("kb_done", done_o, 1'b1);
    chk("kb_acks", ack_cnt, 32'd5);

    // ERROR on beat 3 of an 8-beat read at 0x0
    issue(1'b0, 64'h0, 3'd2, 5'd8, 4'h3);
    tick(1'b1, 1'b0, 32'h0);
    chk("er_c1_htrans", HTRANS, 2'b10);
    tick(1'b1, 1'b0, 32'hA000_0000);
    chk("er_c2_valid", rdat_valid_o, 1'b1);
    tick(1'b1, 1'b0, 32'hA000_0001);
    chk("er_c3_haddr", HADDR, 64'h8);
    chk("er_c3_valid", rdat_valid_o, 1'b1);
    tick(1'b0, 1'b1, 32'h0);
    chk("er_e1_haddr", HADDR, 64'hC);
    chk("er_e1_valid", rdat_valid_o, 1'b0);
    tick(1'b1, 1'b1, 32'h0);
    chk("er_e2_htrans", HTRANS, 2'b00);
    chk("er_e2_valid", rdat_valid_o, 1'b0);
    chk("er_e2_busy", busy_o, 1'b1);
    tick(1'b1, 1'b0, 32'h0);
    chk("er_done", done_o, 1'b1);
    chk("er_err", err_o, 1'b1);
    chk("er_htrans", HTRANS, 2'b00);
    chk("er_reads", rd_cnt, 32'd6);
    tick(1'b1, 1'b0, 32'h0);
    chk("er_done_pulse", done_o, 1'b0);

    // Back-to-back: second command offered in the done cycle of the first
    issue(1'b1, 64'h10, 3'd2, 5'd1, 4'h3);
    tick(1'b1, 1'b0, 32'h0);
    chk("bb_c1_haddr", HADDR, 64'h10);
    tick(1'b1, 1'b0, 32'h0);
    chk("bb_c2_hwdata", HWDATA, 32'hDEAD_BEF4);
    tick(1'b1, 1'b0, 32'h0);
    chk("bb_c3_done", done_o, 1'b1);
    issue(1'b0, 64'h20, 3'd2, 5'd2, 4'h3);
    tick(1'b1, 1'b0, 32'h0);
    chk("bb_c4_htrans", HTRANS, 2'b10);
    chk("bb_c4_haddr", HADDR, 64'h20);
    chk("bb_c4_hwrite", HWRITE, 1'b0);
    chk("bb_c4_busy", busy_o, 1'b1);
    tick(1'b1, 1'b0, 32'hB000_0000);
    chk("bb_c5_haddr", HADDR, 64'h24);
    tick(1'b1, 1'b0, 32'hB000_0001);
    chk("bb_c6_rdat", rdat_o, 32'hB000_0001);
    tick(1'b1, 1'b0, 32'h0);
    chk("bb_done", done_o, 1'b1);

    // Length 0 behaves as 1; start address aligned down to halfword
    issue(1'b0, 64'h103, 3'd1, 5'd0, 4'h3);
    tick(1'b1, 1'b0, 32'h0);
    chk("al_haddr", HADDR, 64'h102);
    chk("al_hburst", HBURST, 3'b000);
    chk("al_hsize", HSIZE, 3'd1);
    tick(1'b1, 1'b0, 32'h5555_1234);
    chk("al_htrans", HTRANS, 2'b00);
    chk("al_rdat", rdat_o, 32'h5555_1234);
    tick(1'b1, 1'b0, 32'h0);
    chk("al_done", done_o, 1'b1);

    // Reset during beat 3 of an 8-beat read
    issue(1'b0, 64'h80, 3'd2, 5'd8, 4'h5);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h1);
    tick(1'b1, 1'b0, 32'h2);
    chk("rs_c3_haddr", HADDR, 64'h88);
    HRESET = 1'b1;
    tick(1'b1, 1'b0, 32'h0);
    chk("rs_htrans", HTRANS, 2'b00);
    chk("rs_haddr", HADDR, 64'h0);
    chk("rs_hwdata", HWDATA, 32'h0);
    chk("rs_hprot", HPROT, 4'b0011);
    chk("rs_hsize", HSIZE, 3'b000);
    chk("rs_busy", busy_o, 1'b0);
    chk("rs_valid", rdat_valid_o, 1'b0);
    HRESET = 1'b0;
    repeat (3) tick(1'b1, 1'b0, 32'h0);
    chk("rs_no_done", done_cnt, 32'd7);
    chk("rs_idle", busy_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mpsoc_ahb_spram_initiator.md
# mpsoc_ahb_spram_initiator

AHB-Lite initiator that converts single command requests from a local requester (DMA engine, test sequencer, boot loader) into pipelined AHB-Lite transfers toward the single-port SRAM slaves on the MPSoC bus.
- Supports SINGLE transfers and incrementing bursts of 1–16 beats.
- Handles wait states and two-cycle ERROR responses.
- Splits bursts at 1 KB boundaries.
- Write data is pulled from a FIFO-style source; read data is presented as a valid-qualified stream.

## Interface
- HADDR_SIZE, 64, address width
- HDATA_SIZE, 32, data width (8..1024, power of two)
- HCLK  in  1  bus clock
- HRESET  in  1  reset; synchronous, active-high
- req_i  in  1  command request
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  HADDR_SIZE  start byte address
- req_size_i  in  3  HSIZE encoding; must be ≤ log2(HDATA_SIZE/8)
- req_len_i  in  5  beat count 1..16; 0 is treated as 1
- req_prot_i  in  4  HPROT for the whole command
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o: slave returned ERROR
- wdat_i  in  HDATA_SIZE  write data, FIFO head; must be valid whenever wdat_ack_o is asserted
- wdat_ack_o  out  1  pop strobe for wdat_i
- rdat_o  out  HDATA_SIZE  read data
- rdat_valid_o  out  1  rdat_o valid, one cycle per beat
- HADDR  out  HADDR_SIZE
- HWDATA  out  HDATA_SIZE
- HWRITE  out  1
- HSIZE  out  3
- HBURST  out  3
- HPROT  out  4
- HTRANS  out  2
- HMASTLOCK  out  1  tied 0
- HRDATA  in  HDATA_SIZE
- HREADY  in  1
- HRESP  in  1

## Operation
- States:
  - IDLE: no command active.
  - ADDR: address phase of the first beat.
  - BURST: overlapped address/data phases.
  - LAST: data phase of the final beat only.
  - ERR: error recovery.
- IDLE: a command is accepted when req_i=1 and busy_o=0. The command fields are latched, the start address is aligned down to req_size_i, and the state moves to ADDR.
- ADDR/BURST:
  - HTRANS=NONSEQ on the first beat and on any beat whose address low 10 bits are 0 (1 KB boundary); SEQ otherwise.
  - HBURST = SINGLE (000) when len=1, INCR (001) otherwise.
  - HSIZE and HPROT are taken from the command.
- Beat advance: occurs on every cycle with HREADY=1.
  - Next HADDR = HADDR + (1<<HSIZE).
  - Remaining count decrements.
  - After the final address phase is accepted, the state moves to LAST and HTRANS=IDLE.
- Write beats:
  - When a write address phase is accepted (HREADY=1), wdat_ack_o=1 in that cycle.
  - HWDATA ← wdat_i on the same edge.
  - HWDATA is held through data-phase wait states.
- Read beats: when a read data phase completes with HREADY=1 and HRESP=0, rdat_valid_o=1 and rdat_o=HRDATA in that cycle (combinational pass of the registered bus data).
- Completion: in the cycle after the final data phase completes, done_o=1, err_o as accumulated, busy_o=0, and the state returns to IDLE.
- Back-to-back commands: a new req_i may be accepted in the done_o cycle.
- ERROR response:
  - On HRESP=1 with HREADY=0 (first error cycle), the next cycle drives HTRANS=IDLE and cancels all remaining beats. The cancelled pending address phase does not issue wdat_ack_o.
  - The state moves to ERR and waits for HRESP=1 with HREADY=1, then completes with err_o=1.
  - No rdat_valid_o is issued for the errored beat.
- Reset: HRESET=1 at any point aborts the command. No done_o is issued.

## Timing
- Reset values:
  - HTRANS=00, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=000, HBURST=000, HPROT=0011, HMASTLOCK=0.
  - busy_o=0, done_o=0, err_o=0, wdat_ack_o=0, rdat_valid_o=0, rdat_o=0.
- All bus outputs are registered.
- Accept at edge k: the first NONSEQ is visible in cycle k+1.
- Wait states: all address-phase outputs and HWDATA hold while HREADY=0.
- Zero-wait N-beat command: address phases in cycles k+1..k+N, data phases in cycles k+2..k+N+1, done_o in cycle k+N+2.
- busy_o=1 from cycle k+1 through the cycle before done_o.

## Test plan
- Single write: req addr 0x100, size WORD, len 1, wdat 0xDEADBEEF, HREADY=1.
  - Cycle 1: NONSEQ/SINGLE at 0x100.
  - Cycle 2: HWDATA=0xDEADBEEF.
  - Cycle 3: done_o=1, err_o=0.
- 4-beat read burst at 0x200, WORD, with HREADY=0 for 2 cycles on beat 2.
  - Bus: NONSEQ at 0x200, then SEQ at 0x204, 0x208, 0x20C, all held during the wait.
  - Result: four rdat_valid_o pulses in order; done_o after the last.
- 1 KB crossing: write len 4 at 0x3F8, WORD.
  - Addresses: 0x3F8 SEQ-sequence NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
  - Result: exactly 4 wdat_ack_o pulses.
- Error: read len 8 at 0x0; slave returns ERROR on beat 3.
  - Bus: HTRANS=IDLE in the cycle after the first ERROR cycle; no further beats issued.
  - Result: 2 rdat_valid_o pulses; done_o with err_o=1.
- Back-to-back: a second req_i is held high during the done_o cycle.
  - Required: accepted in that cycle; its NONSEQ appears on the next cycle.
- Reset mid-burst: HRESET=1 during beat 3 of 8.
  - Next cycle: all outputs at reset values; no done_o issued.
